// File: rtl/mem_read_engine_if.sv
// Bus bundle between the memory read engine and its surroundings:
// job control, address FIFO head, memory read port and operand buffer write port.
interface mem_read_engine_if #(
    parameter int ADDR_WIDTH           = 16,
    parameter int MEM_DATA_WIDTH_BYTES = 32
);
    logic                              start_i;
    logic                              clear;
    logic [ADDR_WIDTH-1:0]             fifo_addr;
    logic                              fifo_empty;
    logic                              fifo_pop;
    logic                              mem_req;
    logic [ADDR_WIDTH-1:0]             mem_addr;
    logic                              mem_gnt;
    logic                              mem_rvalid;
    logic [8*MEM_DATA_WIDTH_BYTES-1:0] mem_rdata;
    logic                              valid_data;
    logic [8*MEM_DATA_WIDTH_BYTES-1:0] buf_wdata;
    logic                              busy;
    logic                              err_o;

    // Engine side: issues memory reads and writes the operand buffer.
    modport master (
        input  start_i, clear, fifo_addr, fifo_empty, mem_gnt, mem_rvalid, mem_rdata,
        output fifo_pop, mem_req, mem_addr, valid_data, buf_wdata, busy, err_o
    );

    // Environment side: config, address FIFO, memory and buffer.
    modport slave (
        output start_i, clear, fifo_addr, fifo_empty, mem_gnt, mem_rvalid, mem_rdata,
        input  fifo_pop, mem_req, mem_addr, valid_data, buf_wdata, busy, err_o
    );
endinterface

// File: rtl/mem_read_engine.sv
// Memory read engine: drains the operand address FIFO into memory read
// requests, bounds the number of reads in flight, and forwards returned
// words (in request order) to the operand buffer write port.
module mem_read_engine #(
    parameter int ADDR_WIDTH           = 16,
    parameter int MEM_DATA_WIDTH_BYTES = 32,
    parameter int MAX_OUTSTANDING      = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_read_engine_if.master bus
);
    localparam int DATA_WIDTH = 8 * MEM_DATA_WIDTH_BYTES;
    localparam int CNT_WIDTH  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    load;
    logic                    req_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [CNT_WIDTH-1:0]    cnt;
    logic                    valid_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    err_q;
    logic                    rsp_expected;
    logic                    rsp_stray;

    // A response is legitimate only while reads are in flight; outside IDLE
    // a response with nothing outstanding is a protocol error.
    assign rsp_expected = bus.mem_rvalid & (cnt != '0);
    assign rsp_stray    = bus.mem_rvalid & (cnt == '0) & (state_q != IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and load decision; clear wins over a same-cycle load and
    // credit is judged on the registered count, so a same-cycle response
    // does not free a slot until the next cycle.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.clear) begin
                    state_d = DRAIN;
                end else begin
                    load = ~bus.fifo_empty & (~req_q | bus.mem_gnt) & (cnt < MAX_CNT);
                end
            end
            DRAIN: begin
                if ((cnt == '0) && !req_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request register: a load (re)arms it, an accept without a new load
    // drops it, otherwise request and address hold while the grant is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q  <= 1'b0;
            addr_q <= '0;
        end else if (load) begin
            req_q  <= 1'b1;
            addr_q <= bus.fifo_addr;
        end else if (req_q && bus.mem_gnt) begin
            req_q  <= 1'b0;
        end
    end

    // Outstanding-read counter; the held request is counted from its load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if ((state_q == IDLE) && bus.start_i) begin
            cnt <= '0;
        end else begin
            case ({load, rsp_expected})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Response forwarding: only words returned while running reach the buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            valid_q <= bus.mem_rvalid & (state_q == RUN);
            if (bus.mem_rvalid && (state_q == RUN)) begin
                wdata_q <= bus.mem_rdata;
            end
        end
    end

    // Sticky error flag, cleared only when a new job starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if ((state_q == IDLE) && bus.start_i) begin
            err_q <= 1'b0;
        end else if (rsp_stray) begin
            err_q <= 1'b1;
        end
    end

    assign bus.fifo_pop   = load;
    assign bus.mem_req    = req_q;
    assign bus.mem_addr   = addr_q;
    assign bus.valid_data = valid_q;
    assign bus.buf_wdata  = wdata_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.err_o      = err_q;
endmodule
